// File: rtl/lw_sha_pkg.sv
// Shared types and constants for the lightweight SHA message scheduler.
// Word width follows CORE_ARCH_S64 (64-bit words, SHA-512 capable) or defaults to 32.
`ifndef WORD_SIZE
`ifdef CORE_ARCH_S64
`define WORD_SIZE 64
`else
`define WORD_SIZE 32
`endif
`endif

package lw_sha_pkg;

  localparam int unsigned WORD_W          = `WORD_SIZE;
  localparam int unsigned SCHED_WIN_DEPTH = 16;
  localparam int unsigned ROUNDS_256      = 64;
  localparam int unsigned ROUNDS_512      = 80;
  localparam int unsigned IDX_W           = 7;
  localparam int unsigned SLOT_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } sched_state_t;

  typedef logic [SCHED_WIN_DEPTH-1:0][WORD_W-1:0] sched_win_t;

  // Index of the final schedule word for the selected mode.
  function automatic logic [IDX_W-1:0] last_round(input logic mode);
    return mode ? IDX_W'(ROUNDS_512 - 1) : IDX_W'(ROUNDS_256 - 1);
  endfunction

endpackage

// File: rtl/lw_sha_expansion.sv
// Combinational SHA-2 message expansion over a 16-slot circular window.
// Slot round_index holds W_{t-16}; the result is W_t. SHA-512 path only under CORE_ARCH_S64.
module lw_sha_expansion
  import lw_sha_pkg::*;
(
  input  logic [SLOT_W-1:0] round_index,
  input  sched_win_t        w,
`ifdef CORE_ARCH_S64
  input  logic              mode,
`endif
  output logic [WORD_W-1:0] result
);

  logic [SLOT_W-1:0] idx_15;
  logic [SLOT_W-1:0] idx_7;
  logic [SLOT_W-1:0] idx_2;
  logic [WORD_W-1:0] w_16;
  logic [WORD_W-1:0] w_15;
  logic [WORD_W-1:0] w_7;
  logic [WORD_W-1:0] w_2;
  logic [31:0]       sum_256;

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window slots wrap mod 16, so older words sit at fixed offsets from round_index.
  assign idx_15 = round_index + SLOT_W'(1);
  assign idx_7  = round_index + SLOT_W'(9);
  assign idx_2  = round_index + SLOT_W'(14);

  assign w_16 = w[round_index];
  assign w_15 = w[idx_15];
  assign w_7  = w[idx_7];
  assign w_2  = w[idx_2];

  assign sum_256 = sig1_256(w_2[31:0]) + w_7[31:0] + sig0_256(w_15[31:0]) + w_16[31:0];

`ifdef CORE_ARCH_S64
  logic [63:0] sum_512;

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  assign sum_512 = sig1_512(w_2) + w_7 + sig0_512(w_15) + w_16;
  assign result  = mode ? sum_512 : {32'd0, sum_256};
`else
  assign result = sum_256;
`endif

endmodule

// File: rtl/lw_sha_msg_scheduler.sv
// Loads a 16-word block and streams the SHA-2 message schedule over valid/ready.
// Options: CORE_ARCH_S64 (64-bit words, mode port), LW_SHA_SCHED_WIPE_EN (window zeroize).
module lw_sha_msg_scheduler
  import lw_sha_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CORE_ARCH_S64
  input  logic                  mode,
`endif
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [`WORD_SIZE-1:0] in_word,
  output logic                  in_ready,
  output logic                  w_valid,
  output logic [`WORD_SIZE-1:0] w_word,
  output logic [IDX_W-1:0]      w_index,
  input  logic                  w_ready,
  output logic                  busy,
  output logic                  done
);

  sched_state_t      state;
  sched_win_t        win;
  logic [IDX_W-1:0]  t;
  logic [SLOT_W-1:0] cnt;
  logic              mode_q;
  logic [WORD_W-1:0] exp_word;
  logic [WORD_W-1:0] load_word;
`ifdef LW_SHA_SCHED_WIPE_EN
  logic              wipe_quiet;
`endif

  lw_sha_expansion u_expansion (
    .round_index (t[SLOT_W-1:0]),
    .w           (win),
`ifdef CORE_ARCH_S64
    .mode        (mode_q),
`endif
    .result      (exp_word)
  );

  // SHA-256 in a 64-bit build keeps the upper half of every window word at zero.
`ifdef CORE_ARCH_S64
  assign load_word = mode_q ? in_word : {32'd0, in_word[31:0]};
`else
  assign load_word = in_word;
`endif

  assign w_index = t;
  assign w_word  = w_valid ? ((t < IDX_W'(SCHED_WIN_DEPTH)) ? win[t[SLOT_W-1:0]] : exp_word)
                           : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= '0;
      t          <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      in_ready   <= 1'b0;
      w_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef LW_SHA_SCHED_WIPE_EN
      wipe_quiet <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        t        <= '0;
        cnt      <= '0;
        in_ready <= 1'b0;
        w_valid  <= 1'b0;
`ifdef LW_SHA_SCHED_WIPE_EN
        // An aborted block is still scrubbed, but without reporting completion.
        if (state != IDLE) begin
          state      <= FIN;
          busy       <= 1'b1;
          wipe_quiet <= 1'b1;
        end
`else
        state    <= IDLE;
        busy     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
`ifdef CORE_ARCH_S64
              mode_q <= mode;
`else
              mode_q <= 1'b0;
`endif
              cnt      <= '0;
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
          LOAD: begin
            if (in_valid) begin
              win[cnt] <= load_word;
              cnt      <= cnt + SLOT_W'(1);
              if (cnt == SLOT_W'(SCHED_WIN_DEPTH - 1)) begin
                state    <= RUN;
                t        <= '0;
                in_ready <= 1'b0;
                w_valid  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_valid && w_ready) begin
              // Expanded words overwrite W_{t-16}, which is no longer needed.
              if (t >= IDX_W'(SCHED_WIN_DEPTH)) begin
                win[t[SLOT_W-1:0]] <= w_word;
              end
              if (t == last_round(mode_q)) begin
                state   <= FIN;
                t       <= '0;
                cnt     <= '0;
                w_valid <= 1'b0;
`ifdef LW_SHA_SCHED_WIPE_EN
                wipe_quiet <= 1'b0;
`else
                done    <= 1'b1;
`endif
              end else begin
                t <= t + IDX_W'(1);
              end
            end
          end
          FIN: begin
`ifdef LW_SHA_SCHED_WIPE_EN
            win[cnt] <= '0;
            cnt      <= cnt + SLOT_W'(1);
            if (cnt == SLOT_W'(SCHED_WIN_DEPTH - 1)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= !wipe_quiet;
              wipe_quiet <= 1'b0;
              cnt        <= '0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lw_sha_msg_scheduler.sv
// Self-checking bench for lw_sha_msg_scheduler against an array-based SHA-2 schedule model.
module tb_lw_sha_msg_scheduler;
  import lw_sha_pkg::*;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
`ifdef CORE_ARCH_S64
  logic              mode     = 1'b0;
`endif
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_word  = '0;
  logic              w_ready  = 1'b0;
  logic              in_ready;
  logic              w_valid;
  logic [WORD_W-1:0] w_word;
  logic [6:0]        w_index;
  logic              busy;
  logic              done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] blk   [16];
  logic [63:0] ref_w [80];
  int          n_rounds = 64;
  logic        is512 = 1'b0;
  logic        use_k = 1'b0;
  logic [63:0] k16 = '0;
  logic [63:0] k17 = '0;

  always #5 clk = ~clk;

  lw_sha_msg_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CORE_ARCH_S64
    .mode     (mode),
`endif
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .w_valid  (w_valid),
    .w_word   (w_word),
    .w_index  (w_index),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Textbook W[t] recurrence over the whole schedule array.
  task automatic compute_ref();
    logic [63:0] a, b;
    logic [31:0] a32, b32, s32;
    for (int k = 0; k < 80; k++) begin
      if (k < 16) begin
        ref_w[k] = blk[k];
      end else if (is512) begin
        a = ref_w[k-15];
        b = ref_w[k-2];
        ref_w[k] = (r64(b, 19) ^ r64(b, 61) ^ (b >> 6)) + ref_w[k-7] +
                   (r64(a, 1) ^ r64(a, 8) ^ (a >> 7)) + ref_w[k-16];
      end else begin
        a32 = ref_w[k-15][31:0];
        b32 = ref_w[k-2][31:0];
        s32 = (r32(b32, 17) ^ r32(b32, 19) ^ (b32 >> 10)) + ref_w[k-7][31:0] +
              (r32(a32, 7) ^ r32(a32, 18) ^ (a32 >> 3)) + ref_w[k-16][31:0];
        ref_w[k] = {32'd0, s32};
      end
    end
    n_rounds = is512 ? 80 : 64;
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0]  = is512 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    blk[15] = 64'h18;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 16; k++)
      blk[k] = is512 ? {$urandom, $urandom} : {32'd0, $urandom};
  endtask

  task automatic load_block(input int gap_pct, output int lcyc);
    int i;
    i    = 0;
    lcyc = 0;
`ifdef CORE_ARCH_S64
    mode = is512;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_in_ready", 64'(in_ready), 64'd1);
    chk("load_busy", 64'(busy), 64'd1);
    while (i < 16 && lcyc < 400) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      // Upper-half garbage must be discarded in SHA-256 mode of a 64-bit build.
      in_word  = WORD_W'(blk[i] | (is512 ? 64'd0 : {$urandom, 32'd0}));
      @(negedge clk);
      lcyc++;
      if (in_valid) i++;
      chk("load_w_valid", 64'(w_valid), (i == 16) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0;
    chk("load_complete", 64'(i), 64'd16);
    chk("load_in_ready_end", 64'(in_ready), 64'd0);
  endtask

  task automatic run_words(input int ready_pct, input int abort_t, output int rcyc);
    int          t;
    logic        stalled;
    logic [63:0] hold_w;
    t       = 0;
    rcyc    = 0;
    stalled = 1'b0;
    hold_w  = '0;
    while (t < n_rounds && rcyc < 2000) begin
      chk("run_w_valid", 64'(w_valid), 64'd1);
      chk("run_w_index", 64'(w_index), 64'(t));
      chk("run_w_word", 64'(w_word), ref_w[t]);
      chk("run_done_low", 64'(done), 64'd0);
      if (stalled) chk("stall_stable", 64'(w_word), hold_w);
      if (use_k && t == 16) chk("abc_w16", 64'(w_word), k16);
      if (use_k && t == 17) chk("abc_w17", 64'(w_word), k17);
      if (t == abort_t) begin
        abort   = 1'b1;
        w_ready = 1'($urandom_range(1));
        @(negedge clk);
        abort   = 1'b0;
        w_ready = 1'b0;
        chk("abort_w_valid", 64'(w_valid), 64'd0);
        chk("abort_w_index", 64'(w_index), 64'd0);
`ifdef LW_SHA_SCHED_WIPE_EN
        for (int k = 0; k < 16; k++) begin
          chk("abort_wipe_busy", 64'(busy), 64'd1);
          chk("abort_wipe_done", 64'(done), 64'd0);
          @(negedge clk);
        end
`endif
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("abort_done_later", 64'(done), 64'd0);
        return;
      end
      w_ready = ($urandom_range(99) < ready_pct);
      hold_w  = 64'(w_word);
      stalled = !w_ready;
      @(negedge clk);
      rcyc++;
      if (w_ready) t++;
    end
    w_ready = 1'b0;
    chk("run_all_words", 64'(t), 64'(n_rounds));
    chk("fin_w_valid", 64'(w_valid), 64'd0);
`ifdef LW_SHA_SCHED_WIPE_EN
    for (int k = 0; k < 16; k++) begin
      chk("wipe_busy", 64'(busy), 64'd1);
      chk("wipe_done_low", 64'(done), 64'd0);
      start = (k < 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("wipe_done", 64'(done), 64'd1);
    chk("wipe_idle_busy", 64'(busy), 64'd0);
    chk("wipe_start_ignored", 64'(in_ready), 64'd0);
    for (int k = 0; k < 16; k++) chk("wipe_slot_zero", 64'(dut.win[k]), 64'd0);
`else
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_busy", 64'(busy), 64'd1);
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int lc, rc;

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_w_word", 64'(w_word), 64'd0);
    chk("rst_w_index", 64'(w_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SHA-256 "abc": 16 load cycles + 64 run cycles, done in the 81st.
    is512 = 1'b0;
    set_abc();
    compute_ref();
    use_k = 1'b1;
    k16   = 64'h6162_6380;
    k17   = 64'h000F_0000;
    load_block(0, lc);
    run_words(100, -1, rc);
    chk("abc_latency", 64'(lc + rc), 64'd80);

    // Same block under random back-pressure.
    load_block(0, lc);
    run_words(50, -1, rc);
    use_k = 1'b0;

    for (int r = 0; r < 3; r++) begin
      set_rand();
      compute_ref();
      load_block($urandom_range(40), lc);
      run_words($urandom_range(20, 90), -1, rc);
    end

    // Abort mid-run, then a full fresh schedule.
    set_rand();
    compute_ref();
    load_block(0, lc);
    run_words(70, 30, rc);
    set_rand();
    compute_ref();
    load_block(20, lc);
    run_words(60, -1, rc);

    // Reset during LOAD after 7 words.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_word  = WORD_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_w_valid", 64'(w_valid), 64'd0);
    chk("arst_w_word", 64'(w_word), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    set_rand();
    compute_ref();
    load_block(0, lc);
    run_words(100, -1, rc);

    // Simultaneous start and abort in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_in_ready", 64'(in_ready), 64'd0);
    chk("start_abort_busy", 64'(busy), 64'd0);

`ifdef CORE_ARCH_S64
    is512 = 1'b1;
    set_abc();
    compute_ref();
    use_k = 1'b1;
    k16   = 64'h6162_6380_0000_0000;
    k17   = ref_w[17];
    load_block(0, lc);
    run_words(100, -1, rc);
    chk("abc512_latency", 64'(lc + rc), 64'd96);
    use_k = 1'b0;
    set_rand();
    compute_ref();
    load_block(25, lc);
    run_words(50, -1, rc);
    is512 = 1'b0;
    set_rand();
    compute_ref();
    load_block(10, lc);
    run_words(80, -1, rc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
